// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants, encodings and helpers for the IF stage
package fetch_unit_pkg;

   // Instruction word loaded into IF/ID when no real instruction is available
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   // Redirect target selection driven by Decode
   typedef enum logic [1:0] {
      SEL_PCIMD2EXT = 2'b00,
      SEL_PCINDEX   = 2'b01,
      SEL_REGA      = 2'b10,
      SEL_EXC       = 2'b11
   } seltipopc_e;

   // Fetch FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_REQ     = 2'b01,
      ST_HOLD    = 2'b10,
      ST_DISCARD = 2'b11
   } fetch_state_e;

   // Sequential PC advance; wraps modulo 2^32
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// rtl/fetch_pc_sel.sv - redirect target mux with word alignment and misalign detect
//
// Ports:
//   i_seltipopc  in  2   target select (pcimd2ext / pcindex / rega / exception vector)
//   i_pcimd2ext  in  32  branch target
//   i_pcindex    in  32  J/JAL target
//   i_rega       in  32  register target (JR/JALR)
//   o_target     out 32  selected target with bits [1:0] cleared
//   o_misalign   out 1   selected target had nonzero bits [1:0]
module fetch_pc_sel
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
   input  logic [1:0]  i_seltipopc,
   input  logic [31:0] i_pcimd2ext,
   input  logic [31:0] i_pcindex,
   input  logic [31:0] i_rega,
   output logic [31:0] o_target,
   output logic        o_misalign
);

   logic [31:0] w_raw;

   always_comb begin
      w_raw = i_pcimd2ext;
      case (i_seltipopc)
         SEL_PCIMD2EXT: w_raw = i_pcimd2ext;
         SEL_PCINDEX:   w_raw = i_pcindex;
         SEL_REGA:      w_raw = i_rega;
         SEL_EXC:       w_raw = EXC_VECTOR;
         default:       w_raw = i_pcimd2ext;
      endcase
   end

   assign o_target   = w_raw & ~32'd3;
   assign o_misalign = |w_raw[1:0];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, instruction-memory req/ack, IF/ID register
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   fw_if_id_stall      hold IF/ID and PC (load-use stall)
//   id_if_selfontepc    redirect request from Decode
//   id_if_seltipopc     redirect target select
//   id_if_pcimd2ext, id_if_pcindex, id_if_rega   redirect target candidates
//   if_mem_req/addr     instruction read request and word address
//   mem_if_ack/data     read completion and instruction word
//   if_id_instrucao     IF/ID instruction (NOP when bubble)
//   if_id_proximopc     PC+4 of the IF/ID instruction
//   if_id_valid         IF/ID holds a real instruction
//   if_misalign         one-cycle pulse: redirect target was not word aligned
//   if_fetch_count      instructions delivered to IF/ID (wraps)
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fw_if_id_stall,
   input  logic        id_if_selfontepc,
   input  logic [1:0]  id_if_seltipopc,
   input  logic [31:0] id_if_pcimd2ext,
   input  logic [31:0] id_if_pcindex,
   input  logic [31:0] id_if_rega,
   output logic        if_mem_req,
   output logic [31:0] if_mem_addr,
   input  logic        mem_if_ack,
   input  logic [31:0] mem_if_data,
   output logic [31:0] if_id_instrucao,
   output logic [31:0] if_id_proximopc,
   output logic        if_id_valid,
   output logic        if_misalign,
   output logic [31:0] if_fetch_count
);

   fetch_state_e r_state;
   fetch_state_e w_state_next;

   logic [31:0] r_pc;
   logic [31:0] r_hold;
   logic [31:0] r_instr;
   logic [31:0] r_proxpc;
   logic        r_valid;
   logic        r_misalign;
   logic [31:0] r_count;

   logic [31:0] w_target;
   logic        w_target_misalign;
   logic        w_redir;
   logic        w_req;
   logic        w_ld_mem;
   logic        w_ld_hold;
   logic        w_capture;
   logic        w_bubble;
   logic        w_pc_inc;

   fetch_pc_sel #(
      .EXC_VECTOR (EXC_VECTOR)
   ) u_pc_sel (
      .i_seltipopc (id_if_seltipopc),
      .i_pcimd2ext (id_if_pcimd2ext),
      .i_pcindex   (id_if_pcindex),
      .i_rega      (id_if_rega),
      .o_target    (w_target),
      .o_misalign  (w_target_misalign)
   );

   // A redirect only counts when the branch really sits in IF/ID and the
   // pipeline is moving; under stall the branch is re-evaluated later.
   assign w_redir = id_if_selfontepc & r_valid & ~fw_if_id_stall;

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_req        = 1'b0;
      w_ld_mem     = 1'b0;
      w_ld_hold    = 1'b0;
      w_capture    = 1'b0;
      w_bubble     = 1'b0;
      w_pc_inc     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_state_next = ST_REQ;
         end
         ST_REQ: begin
            w_req = 1'b1;
            if (w_redir) begin
               // Wrong-path word: drop it if it arrives now, else wait it out
               w_bubble = 1'b1;
               if (!mem_if_ack) w_state_next = ST_DISCARD;
            end else if (mem_if_ack && !fw_if_id_stall) begin
               w_ld_mem = 1'b1;
               w_pc_inc = 1'b1;
            end else if (mem_if_ack) begin
               w_capture    = 1'b1;
               w_state_next = ST_HOLD;
            end else if (!fw_if_id_stall) begin
               w_bubble = 1'b1;
            end
         end
         ST_HOLD: begin
            if (w_redir) begin
               w_bubble     = 1'b1;
               w_state_next = ST_REQ;
            end else if (!fw_if_id_stall) begin
               w_ld_hold    = 1'b1;
               w_pc_inc     = 1'b1;
               w_state_next = ST_REQ;
            end
         end
         ST_DISCARD: begin
            // The stale request must complete before the new PC is issued
            if (!fw_if_id_stall) w_bubble = 1'b1;
            if (mem_if_ack) w_state_next = ST_REQ;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_hold     <= NOP_WORD;
         r_instr    <= NOP_WORD;
         r_proxpc   <= 32'd0;
         r_valid    <= 1'b0;
         r_misalign <= 1'b0;
         r_count    <= 32'd0;
      end else begin
         if (w_redir)       r_pc <= w_target;
         else if (w_pc_inc) r_pc <= pc_plus4(r_pc);

         r_misalign <= w_redir & w_target_misalign;

         if (w_capture) r_hold <= mem_if_data;

         if (w_ld_mem) begin
            r_instr  <= mem_if_data;
            r_proxpc <= pc_plus4(r_pc);
            r_valid  <= 1'b1;
            r_count  <= r_count + 32'd1;
         end else if (w_ld_hold) begin
            r_instr  <= r_hold;
            r_proxpc <= pc_plus4(r_pc);
            r_valid  <= 1'b1;
            r_count  <= r_count + 32'd1;
         end else if (w_bubble) begin
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
         end
      end
   end

   assign if_mem_req      = w_req;
   assign if_mem_addr     = r_pc;
   assign if_id_instrucao = r_instr;
   assign if_id_proximopc = r_proxpc;
   assign if_id_valid     = r_valid;
   assign if_misalign     = r_misalign;
   assign if_fetch_count  = r_count;

endmodule
